sync_fifo_mc_regs: RTL and testbench
====================================

# sync_fifo_mc_regs

Multi-channel register-mapped synchronous FIFO; successor to the single-channel register-mapped FIFO. Provides NUM_CH independent FIFOs of DATA_WIDTH × FIFO_DEPTH behind one simple register bus (reg_* strobes from the AXI4-Lite slave adapter). Each channel has programmable almost-full/almost-empty thresholds, sticky error flags and a max-level watermark. A shared W1C interrupt block drives one level-sensitive irq line.

## Interface
Parameters:
- ADDR_WIDTH, 32: reg_addr width; only reg_addr[8:0] decoded.
- DATA_WIDTH, 32: FIFO word width, 8..32; data zero-extended to 32 on read.
- NUM_CH, 4: channel count, 1..8.
- FIFO_DEPTH, 16: entries per channel, power of 2, 2..32768; LW = $clog2(FIFO_DEPTH)+1.
- AF_RESET, FIFO_DEPTH-1: reset value of every almost-full threshold.
- AE_RESET, 1: reset value of every almost-empty threshold.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_addr  in  ADDR_WIDTH  byte address of current access.
- reg_wdata  in  32  write data.
- reg_be  in  4  byte enables; ignored (full-word semantics).
- reg_we  in  1  write strobe, one cycle per access.
- reg_re  in  1  read strobe, one cycle per access.
- reg_rdata  out  32  combinational read data for reg_addr.
- irq  out  1  OR of (IRQ_STATUS & IRQ_ENABLE), registered state.

## Operation
- Channel c register window base c*0x10: DATA +0x0, STATUS +0x4, CONTROL +0x8, THRESH +0xC. Global: IRQ_STATUS 0x100 (W1C), IRQ_ENABLE 0x104 (RW). Unmapped or channel ≥ NUM_CH: read 0, write ignored.
- DATA write: push reg_wdata[DATA_WIDTH-1:0] if not full; if full, drop word, set sticky ovf, raise IRQ ovf event.
- DATA read: FWFT; reg_rdata = head word (0 when empty); reg_re pops if not empty; if empty, set sticky udf and raise IRQ udf event.
- STATUS: [0] empty, [1] full, [2] almost_empty (level ≤ ae_thr), [3] almost_full (level ≥ af_thr), [4] sticky ovf, [5] sticky udf, [31:16] level zero-extended.
- CONTROL write: [0] flush (level/pointers to 0, stored data discarded), [1] clear sticky ovf/udf, [2] clear max_level. Reads: [31:16] max_level, others 0.
- THRESH: [15:0] ae_thr, [31:16] af_thr, each stored in LW bits (upper bits truncated). No range checking.
- max_level: per channel, updated to max(max_level, next level) every cycle; clear loads next level.
- IRQ_STATUS bit 4c+k for channel c: k=0 ovf event, k=1 udf event, k=2 almost_full rising edge, k=3 almost_empty rising edge. Edges detected against registered previous flag. Write-1 clears; set wins over clear in the same cycle. Bits ≥ 4*NUM_CH read 0.
- Simultaneous reg_we and reg_re: both processed. Push and pop on the same channel: both execute, level unchanged; push accepted even when full (pop frees slot); pop of empty with push: underflow flagged, pushed word stored.
- Flush wins over push/pop in the same cycle; sticky flags, thresholds and max_level unaffected by flush.

## Timing
- Reset (rst high at clk edge): all channels empty, level 0, max_level 0, sticky 0, ae_thr=AE_RESET, af_thr=AF_RESET, IRQ_STATUS 0, IRQ_ENABLE 0, irq 0, edge-history registers loaded with post-reset flags (empty channel with AE_RESET ≥ 0 → no spurious AE edge). Reset mid-operation discards all data the same edge.
- Push/pop/flush/register writes take effect at the clk edge ending the strobe cycle; STATUS, level and flags reflect it the next cycle.
- reg_rdata valid in the strobe cycle (combinational from address and current state); the popped word is the one returned.
- IRQ_STATUS bit set at the edge ending the event cycle; irq asserts the following cycle (1 cycle after the event), deasserts 1 cycle after W1C write or enable clear.
- Pointers wrap modulo FIFO_DEPTH; level range 0..FIFO_DEPTH in LW bits.

## Test plan
- Reset, read STATUS ch0 → 0x0000_0005 (empty, almost_empty); THRESH → {AF_RESET, AE_RESET}=0x000F_0001; irq 0.
- Push 16 words 0x100..0x10F to ch1, 17th 0x1FF → STATUS ch1 = 0x0010_001A (full, af, ovf); pop 16 returns 0x100..0x10F in order; 17th pop returns 0, udf set.
- Enable IRQ bits 4..7, fill ch1 to 15 entries → IRQ_STATUS bit 6 set, irq high one cycle later; write 0x40 to IRQ_STATUS → irq low next cycle.
- Push 5 to ch2, same-cycle push+pop on ch2 → level stays 5, head advances; CONTROL ch2=0x1 → level 0, CONTROL[31:16] still 5; CONTROL=0x4 → max_level 0.
- Interleave pushes to ch0 and ch3 (0xA0.., 0xD0..) → no cross-channel data or flag leakage; assert rst with data pending → all levels 0 next cycle.

Source files
------------

// File: rtl/sync_fifo_mc_regs.sv
// rtl/sync_fifo_mc_regs.sv - multi-channel register-mapped synchronous FIFO with W1C interrupt block
module sync_fifo_mc_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_RESET   = FIFO_DEPTH - 1,
    parameter int AE_RESET   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           reg_wdata,
    input  logic [3:0]            reg_be,
    input  logic                  reg_we,
    input  logic                  reg_re,
    output logic [31:0]           reg_rdata,
    output logic                  irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = 4 * NUM_CH;
    localparam logic [LW-1:0] AF_INIT = LW'(AF_RESET);
    localparam logic [LW-1:0] AE_INIT = LW'(AE_RESET);

    logic [8:0] a;
    assign a = reg_addr[8:0];

    // Byte enables and address bits above [8] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{reg_be, reg_addr, reg_wdata};

    logic [NUM_CH-1:0]       ch_sel;
    logic [NUM_CH-1:0][31:0] ch_data_rd;
    logic [NUM_CH-1:0][31:0] ch_status_rd;
    logic [NUM_CH-1:0][31:0] ch_ctrl_rd;
    logic [NUM_CH-1:0][31:0] ch_thresh_rd;
    logic [IW-1:0]           irq_set;
    logic [IW-1:0]           irq_status;
    logic [IW-1:0]           irq_enable;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [LW-1:0] level, level_nxt, max_level, ae_thr, af_thr;
        logic ovf, udf, af_prev, ae_prev;
        logic push_req, pop_req, ctrl_wr, thr_wr;
        logic do_push, do_pop, flush, full, empty, ae, af;
        logic ovf_evt, udf_evt;

        assign ch_sel[c] = !a[8] && (a[7:4] == 4'(c)) && (a[1:0] == 2'b00);
        assign push_req  = reg_we && ch_sel[c] && (a[3:2] == 2'd0);
        assign pop_req   = reg_re && ch_sel[c] && (a[3:2] == 2'd0);
        assign ctrl_wr   = reg_we && ch_sel[c] && (a[3:2] == 2'd2);
        assign thr_wr    = reg_we && ch_sel[c] && (a[3:2] == 2'd3);

        assign empty   = (level == '0);
        assign full    = (level == LW'(FIFO_DEPTH));
        assign ae      = (level <= ae_thr);
        assign af      = (level >= af_thr);
        assign flush   = ctrl_wr && reg_wdata[0];
        // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
        assign do_pop  = pop_req && !empty;
        assign do_push = push_req && (!full || do_pop);
        assign ovf_evt = push_req && full && !do_pop;
        assign udf_evt = pop_req && empty;

        always_comb begin
            level_nxt = level;
            if (flush)
                level_nxt = '0;
            else if (do_push && !do_pop)
                level_nxt = level + LW'(1);
            else if (do_pop && !do_push)
                level_nxt = level - LW'(1);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                max_level <= '0;
                ovf       <= 1'b0;
                udf       <= 1'b0;
                ae_thr    <= AE_INIT;
                af_thr    <= AF_INIT;
                // History matches the post-reset flags so reset itself is not an edge.
                af_prev   <= (AF_INIT == '0);
                ae_prev   <= 1'b1;
            end else begin
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + PW'(1);
                    if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
                end
                level <= level_nxt;
                if (ctrl_wr && reg_wdata[2])
                    max_level <= level_nxt;
                else if (level_nxt > max_level)
                    max_level <= level_nxt;
                ovf <= (ovf && !(ctrl_wr && reg_wdata[1])) || ovf_evt;
                udf <= (udf && !(ctrl_wr && reg_wdata[1])) || udf_evt;
                if (thr_wr) begin
                    ae_thr <= reg_wdata[LW-1:0];
                    af_thr <= reg_wdata[16 +: LW];
                end
                af_prev <= af;
                ae_prev <= ae;
            end
        end

        always_ff @(posedge clk) begin
            if (do_push && !flush)
                mem[wr_ptr] <= reg_wdata[DATA_WIDTH-1:0];
        end

        assign ch_data_rd[c]   = empty ? 32'd0 : 32'(mem[rd_ptr]);
        assign ch_status_rd[c] = {16'(level), 10'd0, udf, ovf, af, ae, full, empty};
        assign ch_ctrl_rd[c]   = {16'(max_level), 16'd0};
        assign ch_thresh_rd[c] = {16'(af_thr), 16'(ae_thr)};
        assign irq_set[4*c +: 4] = {ae && !ae_prev, af && !af_prev, udf_evt, ovf_evt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status <= '0;
            irq_enable <= '0;
        end else begin
            // New events win over a same-cycle write-1-to-clear.
            irq_status <= (irq_status & ~((reg_we && a == 9'h100) ? reg_wdata[IW-1:0] : '0)) | irq_set;
            if (reg_we && a == 9'h104)
                irq_enable <= reg_wdata[IW-1:0];
        end
    end

    assign irq = |(irq_status & irq_enable);

    always_comb begin
        reg_rdata = '0;
        if (a == 9'h100)
            reg_rdata = 32'(irq_status);
        else if (a == 9'h104)
            reg_rdata = 32'(irq_enable);
        else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel[c]) begin
                    case (a[3:2])
                        2'd0:    reg_rdata = ch_data_rd[c];
                        2'd1:    reg_rdata = ch_status_rd[c];
                        2'd2:    reg_rdata = ch_ctrl_rd[c];
                        default: reg_rdata = ch_thresh_rd[c];
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_mc_regs.sv
// tb/tb_sync_fifo_mc_regs.sv - self-checking bench for sync_fifo_mc_regs with a queue-based reference model
module tb_sync_fifo_mc_regs;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [3:0]  reg_be = 4'hF;
    logic        reg_we = 1'b0;
    logic        reg_re = 1'b0;
    logic [31:0] reg_rdata;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    int unsigned mq [NCH][$];
    int          m_ae [NCH];
    int          m_af [NCH];
    int          m_max [NCH];
    bit          m_ovf [NCH];
    bit          m_udf [NCH];
    bit          m_afp [NCH];
    bit          m_aep [NCH];
    logic [15:0] m_ist;
    logic [15:0] m_ien;

    always #5 clk = ~clk;

    sync_fifo_mc_regs #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .irq(irq)
    );

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_ae[c] = 1;
            m_af[c] = DEPTH - 1;
            m_max[c] = 0;
            m_ovf[c] = 0;
            m_udf[c] = 0;
            m_afp[c] = (0 >= m_af[c]);
            m_aep[c] = 1;
        end
        m_ist = '0;
        m_ien = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [8:0] a;
        logic [31:0] st;
        int c, n;
        a = addr[8:0];
        if (a == 9'h100) return {16'h0, m_ist};
        if (a == 9'h104) return {16'h0, m_ien};
        if (a[8] || a[1:0] != 2'b00 || int'(a[7:4]) >= NCH) return 32'h0;
        c = int'(a[7:4]);
        n = mq[c].size();
        case (a[3:2])
            2'd0: return (n == 0) ? 32'h0 : mq[c][0];
            2'd1: begin
                st = 32'(n) << 16;
                st[0] = (n == 0);
                st[1] = (n == DEPTH);
                st[2] = (n <= m_ae[c]);
                st[3] = (n >= m_af[c]);
                st[4] = m_ovf[c];
                st[5] = m_udf[c];
                return st;
            end
            2'd2: return 32'(m_max[c]) << 16;
            default: return (32'(m_af[c]) << 16) | 32'(m_ae[c]);
        endcase
    endfunction

    function automatic void model_step(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] wdata);
        logic [8:0] a;
        logic [15:0] set;
        bit clr_max [NCH];
        bit af, ae, pop;
        int c, n;
        a = addr[8:0];
        set = '0;
        for (int k = 0; k < NCH; k++) begin
            af = mq[k].size() >= m_af[k];
            ae = mq[k].size() <= m_ae[k];
            if (af && !m_afp[k]) set[4*k+2] = 1'b1;
            if (ae && !m_aep[k]) set[4*k+3] = 1'b1;
            m_afp[k] = af;
            m_aep[k] = ae;
            clr_max[k] = 0;
        end
        if (we && a == 9'h100) m_ist = m_ist & ~wdata[15:0];
        if (we && a == 9'h104) m_ien = wdata[15:0];
        if (!a[8] && a[1:0] == 2'b00 && int'(a[7:4]) < NCH) begin
            c = int'(a[7:4]);
            n = mq[c].size();
            case (a[3:2])
                2'd0: begin
                    pop = re && n > 0;
                    if (re && n == 0) begin m_udf[c] = 1; set[4*c+1] = 1'b1; end
                    if (pop) void'(mq[c].pop_front());
                    if (we) begin
                        if (n < DEPTH || pop) mq[c].push_back(wdata);
                        else begin m_ovf[c] = 1; set[4*c] = 1'b1; end
                    end
                end
                2'd2: if (we) begin
                    if (wdata[0]) mq[c].delete();
                    if (wdata[1]) begin m_ovf[c] = 0; m_udf[c] = 0; end
                    if (wdata[2]) clr_max[c] = 1;
                end
                2'd3: if (we) begin
                    m_ae[c] = int'(wdata[4:0]);
                    m_af[c] = int'(wdata[20:16]);
                end
                default: ;
            endcase
        end
        m_ist = m_ist | set;
        for (int k = 0; k < NCH; k++)
            if (clr_max[k] || mq[k].size() > m_max[k]) m_max[k] = mq[k].size();
    endfunction

    // Called in the phase just after a rising edge; returns with the same phase one cycle later.
    task automatic access(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got, output logic [31:0] exp);
        reg_we = we; reg_re = re; reg_addr = addr; reg_wdata = wdata;
        exp = model_read(addr);
        @(negedge clk);
        got = reg_rdata;
        @(posedge clk);
        #1;
        model_step(we, re, addr, wdata);
        reg_we = 1'b0; reg_re = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] g, e;
        access(1'b1, 1'b0, addr, data, g, e);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] got, output logic [31:0] exp);
        access(1'b0, 1'b1, addr, 32'h0, got, exp);
    endtask

    task automatic do_reset();
        reg_we = 1'b0; reg_re = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        do_reset();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rd(32'h4, got, exp);
        tests_run++;
        if (got !== 32'h0000_0005) begin tests_failed++; $display("FAIL reset_status: got %h expected %h", got, 32'h5); end
        rd(32'hC, got, exp);
        tests_run++;
        if (got !== 32'h000F_0001) begin tests_failed++; $display("FAIL reset_thresh: got %h expected %h", got, 32'h000F0001); end
        rd(32'h100, got, exp);
        tests_run++;
        if (got !== 32'h0) begin tests_failed++; $display("FAIL reset_irq_status: got %h expected 0", got); end
        rd(32'h38, got, exp);
        tests_run++;
        if (got !== 32'h0) begin tests_failed++; $display("FAIL reset_max_level: got %h expected 0", got); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] got, exp;
        for (int i = 0; i < 16; i++) wr(32'h10, 32'h100 + 32'(i));
        wr(32'h10, 32'h1FF);
        rd(32'h14, got, exp);
        tests_run++;
        if (got !== 32'h0010_001A) begin tests_failed++; $display("FAIL fill_status: got %h expected %h", got, 32'h0010001A); end
        for (int i = 0; i < 16; i++) begin
            rd(32'h10, got, exp);
            tests_run++;
            if (got !== 32'h100 + 32'(i)) begin tests_failed++; $display("FAIL drain_data%0d: got %h expected %h", i, got, 32'h100 + 32'(i)); end
        end
        rd(32'h10, got, exp);
        tests_run++;
        if (got !== 32'h0) begin tests_failed++; $display("FAIL empty_pop: got %h expected 0", got); end
        rd(32'h14, got, exp);
        tests_run++;
        if (got !== 32'h0000_0035) begin tests_failed++; $display("FAIL drain_status: got %h expected %h", got, 32'h35); end
    endtask

    task automatic test_irq();
        logic [31:0] got, exp;
        wr(32'h18, 32'h2);
        wr(32'h100, 32'hFFFF_FFFF);
        wr(32'h104, 32'h0000_00F0);
        for (int i = 0; i < 15; i++) wr(32'h10, $urandom);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_before_edge: got %b expected 0", irq); end
        access(1'b0, 1'b0, 32'h1F0, 32'h0, got, exp);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_af_assert: got %b expected 1", irq); end
        rd(32'h100, got, exp);
        tests_run++;
        if (got[6] !== 1'b1 || got !== exp) begin tests_failed++; $display("FAIL irq_status_af: got %h expected %h", got, exp); end
        wr(32'h100, 32'h40);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_w1c_deassert: got %b expected 0", irq); end
        rd(32'h100, got, exp);
        tests_run++;
        if (got[6] !== 1'b0 || got !== exp) begin tests_failed++; $display("FAIL irq_status_cleared: got %h expected %h", got, exp); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] got, exp;
        logic [31:0] d [6];
        for (int i = 0; i < 6; i++) d[i] = $urandom;
        for (int i = 0; i < 5; i++) wr(32'h20, d[i]);
        access(1'b1, 1'b1, 32'h20, d[5], got, exp);
        tests_run++;
        if (got !== d[0]) begin tests_failed++; $display("FAIL pushpop_data: got %h expected %h", got, d[0]); end
        rd(32'h24, got, exp);
        tests_run++;
        if (got[31:16] !== 16'd5 || got !== exp) begin tests_failed++; $display("FAIL pushpop_level: got %h expected %h", got, exp); end
        access(1'b0, 1'b0, 32'h20, 32'h0, got, exp);
        tests_run++;
        if (got !== d[1]) begin tests_failed++; $display("FAIL pushpop_head: got %h expected %h", got, d[1]); end
        wr(32'h28, 32'h1);
        rd(32'h24, got, exp);
        tests_run++;
        if (got !== 32'h0000_0005) begin tests_failed++; $display("FAIL flush_status: got %h expected %h", got, 32'h5); end
        rd(32'h28, got, exp);
        tests_run++;
        if (got !== 32'h0005_0000) begin tests_failed++; $display("FAIL flush_keeps_max: got %h expected %h", got, 32'h00050000); end
        wr(32'h28, 32'h4);
        rd(32'h28, got, exp);
        tests_run++;
        if (got !== 32'h0) begin tests_failed++; $display("FAIL max_clear: got %h expected 0", got); end
    endtask

    task automatic test_boundaries();
        logic [31:0] got, exp;
        for (int i = 0; i < 16; i++) wr(32'h20, 32'h2000 + 32'(i));
        access(1'b1, 1'b1, 32'h20, 32'h2FFF, got, exp);
        tests_run++;
        if (got !== 32'h2000) begin tests_failed++; $display("FAIL full_pushpop_data: got %h expected %h", got, 32'h2000); end
        rd(32'h24, got, exp);
        tests_run++;
        if (got !== 32'h0010_000A) begin tests_failed++; $display("FAIL full_pushpop_status: got %h expected %h", got, 32'h0010000A); end
        wr(32'h28, 32'h1);
        access(1'b1, 1'b1, 32'h20, 32'h2ABC, got, exp);
        tests_run++;
        if (got !== 32'h0) begin tests_failed++; $display("FAIL empty_pushpop_data: got %h expected 0", got); end
        rd(32'h24, got, exp);
        tests_run++;
        if (got !== 32'h0001_0024) begin tests_failed++; $display("FAIL empty_pushpop_status: got %h expected %h", got, 32'h00010024); end
        access(1'b0, 1'b0, 32'h20, 32'h0, got, exp);
        tests_run++;
        if (got !== 32'h2ABC) begin tests_failed++; $display("FAIL empty_pushpop_stored: got %h expected %h", got, 32'h2ABC); end
    endtask

    task automatic test_interleave();
        logic [31:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            wr(32'h00, 32'hA0 + 32'(i));
            wr(32'h30, 32'hD0 + 32'(i));
        end
        rd(32'h04, got, exp);
        tests_run++;
        if (got !== 32'h0008_0000) begin tests_failed++; $display("FAIL inter_status_ch0: got %h expected %h", got, 32'h00080000); end
        rd(32'h34, got, exp);
        tests_run++;
        if (got !== 32'h0008_0000) begin tests_failed++; $display("FAIL inter_status_ch3: got %h expected %h", got, 32'h00080000); end
        rd(32'h14, got, exp);
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL inter_status_ch1: got %h expected %h", got, exp); end
        for (int i = 0; i < 8; i++) begin
            rd(32'h00, got, exp);
            tests_run++;
            if (got !== 32'hA0 + 32'(i)) begin tests_failed++; $display("FAIL inter_ch0_data%0d: got %h expected %h", i, got, 32'hA0 + 32'(i)); end
            rd(32'h30, got, exp);
            tests_run++;
            if (got !== 32'hD0 + 32'(i)) begin tests_failed++; $display("FAIL inter_ch3_data%0d: got %h expected %h", i, got, 32'hD0 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            wr(32'h00, $urandom);
            wr(32'h10, $urandom);
        end
        reg_we = 1'b1; reg_addr = 32'h20; reg_wdata = 32'hDEAD; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; reg_we = 1'b0;
        model_reset();
        for (int c = 0; c < NCH; c++) begin
            rd(32'(c * 16 + 4), got, exp);
            tests_run++;
            if (got !== 32'h0000_0005) begin tests_failed++; $display("FAIL reset_mid_ch%0d: got %h expected %h", c, got, 32'h5); end
        end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_irq: got %b expected 0", irq); end
    endtask

    task automatic test_random();
        logic [31:0] got, exp, addr, wdata;
        bit we, re;
        int ch;
        for (int i = 0; i < 1200; i++) begin
            ch = $urandom_range(0, NCH - 1);
            wdata = $urandom;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: addr = 32'(ch * 16);
                5: addr = 32'(ch * 16 + 4);
                6: begin
                    addr = 32'(ch * 16 + 8);
                    if ($urandom_range(0, 7) != 0) wdata[0] = 1'b0;
                end
                7: addr = 32'(ch * 16 + 12);
                8: addr = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h104;
                default: case ($urandom_range(0, 3))
                    0: addr = 32'h40;
                    1: addr = 32'h7C;
                    2: addr = 32'h108;
                    default: addr = 32'h1F0;
                endcase
            endcase
            if ($urandom_range(0, 3) == 0) addr[31:9] = 23'($urandom);
            access(we, re, addr, wdata, got, exp);
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL random_rdata[%0d] addr %h: got %h expected %h", i, addr, got, exp); end
            tests_run++;
            if (irq !== |(m_ist & m_ien)) begin tests_failed++; $display("FAIL random_irq[%0d]: got %b expected %b", i, irq, |(m_ist & m_ien)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_drain();
        test_irq();
        test_same_cycle();
        test_boundaries();
        test_interleave();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
